// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit processor pipeline: fetch FSM states,
// the HALT opcode and the instruction size in bytes.
package proc_pkg;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        HALTED,
        ERROR
    } fetch_state_t;

    localparam logic [4:0]  OPC_HALT    = 5'b00000;
    localparam logic [15:0] INSTR_BYTES = 16'd2;

endpackage

// File: rtl/fetch_pc_reg.sv
// Architectural PC register. It either loads a redirect target or steps to
// the next sequential instruction, and it always exposes the sequential successor.
module fetch_pc_reg
    import proc_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        inc,
    input  logic [15:0] load_val,
    output logic [15:0] pc,
    output logic [15:0] pc_inc
);

    // Sequential successor; wraps naturally at 16 bits.
    assign pc_inc = pc + INSTR_BYTES;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc_inc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: holds the PC, runs the imem req/ack handshake and
// hands instructions to execute. Define FETCH_TIMEOUT_EN to bound the imem wait.
module fetch_stage
    import proc_pkg::*;
#(
    parameter logic [15:0] RESET_PC       = 16'h0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] pc_out,
    output logic [15:0] pc_inc,
    input  logic        pc_wr,
    input  logic [15:0] next_pc,
    input  logic        exec_err,
    output logic        halted,
    output logic        err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("fetch_stage: TIMEOUT_CYCLES must be at least 1");
    end

    fetch_state_t state;
    logic [15:0]  pc;
    logic         ack_take;
    logic         accept;
    logic         is_halt;
    logic         bad_target;
    logic         advance;
    logic         pc_load;
    logic         pc_step;

    // The ack only counts once our request is actually on the bus, which
    // drops any ack seen in the first cycle after reset release.
    assign ack_take   = (state == FETCH) && imem_req && imem_ack;
    assign accept     = (state == HOLD) && instr_valid && instr_ready;
    assign is_halt    = (instr[15:11] == OPC_HALT);
    assign bad_target = pc_wr && next_pc[0];
    assign advance    = accept && !exec_err && !bad_target && !is_halt;
    assign pc_load    = advance && pc_wr;
    assign pc_step    = advance && !pc_wr;

    assign imem_addr = pc;
    assign pc_out    = pc;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (pc_load),
        .inc      (pc_step),
        .load_val (next_pc),
        .pc       (pc),
        .pc_inc   (pc_inc)
    );

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_next;

    assign wait_next = wait_cnt + 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            instr       <= 16'h0000;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            halted      <= 1'b0;
            err         <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
        end else begin
            case (state)
                FETCH: begin
                    if (ack_take) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= HOLD;
                    end else begin
                        imem_req <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                        // Only cycles with the request actually raised count as waiting.
                        if (imem_req) begin
                            if (wait_next == WAIT_LIMIT) begin
                                state    <= ERROR;
                                err      <= 1'b1;
                                imem_req <= 1'b0;
                            end else begin
                                wait_cnt <= wait_next;
                            end
                        end
`endif
                    end
                end
                HOLD: begin
                    if (accept) begin
                        instr_valid <= 1'b0;
                        if (exec_err || bad_target) begin
                            state <= ERROR;
                            err   <= 1'b1;
                        end else if (is_halt) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end else begin
                            state    <= FETCH;
                            imem_req <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                            wait_cnt <= '0;
`endif
                        end
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state       <= ERROR;
                    err         <= 1'b1;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
